// File: rtl/sweep_sequencer_if.sv
// Control, phase-table and output bundle of the ultrasonic sweep sequencer.
// The master side drives commands and table data; the slave side is the sequencer.
interface sweep_sequencer_if #(
  parameter int unsigned NUM_CH   = 37,
  parameter int unsigned LISTEN_W = 16
);
  logic                  start;
  logic                  abort;
  logic                  loop_en;
  logic [3:0]            num_steps;
  logic [3:0]            burst_len;
  logic [LISTEN_W-1:0]   listen_len;
  logic                  carrier_tick;
  logic [9:0]            tbl_addr;
  logic [3:0]            tbl_data;
  logic [4*NUM_CH-1:0]   shift_bus;
  logic                  burst_en;
  logic                  cap_en;
  logic [3:0]            step_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, loop_en, num_steps, burst_len, listen_len, carrier_tick, tbl_data,
    input  tbl_addr, shift_bus, burst_en, cap_en, step_idx, busy, done
  );

  modport slave (
    input  start, abort, loop_en, num_steps, burst_len, listen_len, carrier_tick, tbl_data,
    output tbl_addr, shift_bus, burst_en, cap_en, step_idx, busy, done
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Beam-sweep sequencer: per step, loads channel phase shifts from a table, then runs a
// carrier-aligned transmit burst followed by a microphone capture window.
module sweep_sequencer #(
  parameter int unsigned NUM_CH   = 37,
  parameter int unsigned LISTEN_W = 16
) (
  input logic              clk,
  input logic              res_n,
  sweep_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StBurst, StListen, StNext} state_e;

  state_e                state_q;
  logic [3:0]            step_q;
  logic [6:0]            load_cnt_q;
  logic [LISTEN_W-1:0]   tick_cnt_q;
  logic [3:0]            num_steps_q;
  logic [3:0]            burst_len_q;
  logic [LISTEN_W-1:0]   listen_len_q;
  logic                  loop_en_q;
  logic [4*NUM_CH-1:0]   shadow_q;
  logic [4*NUM_CH-1:0]   shift_q;
  logic [9:0]            addr_q;
  logic                  burst_q;
  logic                  cap_q;
  logic                  done_q;

  logic [LISTEN_W-1:0]   tick_nxt;
  logic                  burst_hit;
  logic                  listen_hit;
  logic [6:0]            ch_nxt;
  logic                  last_load;
  logic                  more_steps;
  logic                  step_start;
  logic [4*NUM_CH-1:0]   shadow_nxt;

  always_comb begin
    tick_nxt   = tick_cnt_q + LISTEN_W'(1);
    burst_hit  = (tick_nxt == LISTEN_W'(burst_len_q));
    listen_hit = (tick_nxt == listen_len_q);
    ch_nxt     = load_cnt_q + 7'd1;
    last_load  = (load_cnt_q == 7'(NUM_CH));
    more_steps = (step_q < num_steps_q);
    // Table data trails the address by one cycle, so entries shift in from the top and
    // channel 0 lands in the lowest nibble after NUM_CH shifts.
    shadow_nxt = {bus.tbl_data, shadow_q[4*NUM_CH-1:4]};
    // Per-step configuration is latched on every entry into LOAD.
    step_start = !bus.abort &&
                 (((state_q == StIdle) && bus.start) ||
                  ((state_q == StNext) && (more_steps || loop_en_q)));
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= StIdle;
      step_q       <= 4'd0;
      load_cnt_q   <= 7'd0;
      tick_cnt_q   <= '0;
      num_steps_q  <= 4'd0;
      burst_len_q  <= 4'd0;
      listen_len_q <= '0;
      loop_en_q    <= 1'b0;
      shadow_q     <= '0;
      shift_q      <= '0;
      addr_q       <= 10'd0;
      burst_q      <= 1'b0;
      cap_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (step_start) begin
        num_steps_q  <= bus.num_steps;
        burst_len_q  <= bus.burst_len;
        listen_len_q <= bus.listen_len;
        loop_en_q    <= bus.loop_en;
      end
      if (bus.abort) begin
        state_q <= StIdle;
        burst_q <= 1'b0;
        cap_q   <= 1'b0;
        addr_q  <= {step_q, 6'd0};
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q    <= StLoad;
              step_q     <= 4'd0;
              addr_q     <= 10'd0;
              load_cnt_q <= 7'd0;
            end
          end
          StLoad: begin
            if (load_cnt_q != 7'd0) shadow_q <= shadow_nxt;
            if (last_load) begin
              shift_q <= shadow_nxt;
              addr_q  <= {step_q, 6'd0};
              state_q <= StArm;
            end else begin
              load_cnt_q <= ch_nxt;
              addr_q     <= {step_q, (ch_nxt < 7'(NUM_CH)) ? ch_nxt[5:0] : 6'd0};
            end
          end
          StArm: begin
            if (bus.carrier_tick) begin
              tick_cnt_q <= '0;
              if (burst_len_q != 4'd0) begin
                burst_q <= 1'b1;
                state_q <= StBurst;
              end else if (listen_len_q != '0) begin
                cap_q   <= 1'b1;
                state_q <= StListen;
              end else begin
                state_q <= StNext;
              end
            end
          end
          StBurst: begin
            if (bus.carrier_tick) begin
              if (burst_hit) begin
                burst_q    <= 1'b0;
                tick_cnt_q <= '0;
                if (listen_len_q != '0) begin
                  cap_q   <= 1'b1;
                  state_q <= StListen;
                end else begin
                  state_q <= StNext;
                end
              end else begin
                tick_cnt_q <= tick_nxt;
              end
            end
          end
          StListen: begin
            if (bus.carrier_tick) begin
              if (listen_hit) begin
                cap_q   <= 1'b0;
                state_q <= StNext;
              end else begin
                tick_cnt_q <= tick_nxt;
              end
            end
          end
          StNext: begin
            load_cnt_q <= 7'd0;
            if (more_steps) begin
              step_q  <= step_q + 4'd1;
              addr_q  <= {step_q + 4'd1, 6'd0};
              state_q <= StLoad;
            end else if (loop_en_q) begin
              step_q  <= 4'd0;
              addr_q  <= 10'd0;
              state_q <= StLoad;
            end else begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.tbl_addr  = addr_q;
  assign bus.shift_bus = shift_q;
  assign bus.burst_en  = burst_q;
  assign bus.cap_en    = cap_q;
  assign bus.step_idx  = step_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: table of sweep configurations with hand-computed
// burst/capture cycle totals, plus abort, loop and reset corner cases.
module tb_sweep_sequencer;
  localparam int NCH = 37;
  localparam int SBW = 4 * NCH;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  sweep_sequencer_if #(.NUM_CH(NCH), .LISTEN_W(16)) bus ();

  sweep_sequencer #(.NUM_CH(NCH), .LISTEN_W(16)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    int ns;
    int bl;
    int ll;
    int period;
    bit poke;
    int exp_burst;
    int exp_cap;
    int exp_steps;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period = 10;
  int tick_ctr = 0;
  int n_burst = 0, n_cap = 0, n_done = 0, n_overlap = 0, n_sbchg = 0;
  int step_log[$];
  logic [5:0]     prev_ch = 6'd0;
  logic [SBW-1:0] sb_prev = '0;

  function automatic logic [3:0] tbl_val(input logic [9:0] a);
    return 4'((int'(a[9:6]) * 3 + int'(a[5:0])) % 16);
  endfunction

  function automatic logic [SBW-1:0] bank(input int step);
    logic [SBW-1:0] b;
    b = '0;
    for (int c = 0; c < NCH; c++) b[4*c +: 4] = 4'((step * 3 + c) % 16);
    return b;
  endfunction

  // Phase table: data for an address appears one cycle after it.
  always @(posedge clk) bus.tbl_data <= tbl_val(bus.tbl_addr);

  initial begin
    bus.carrier_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_ctr >= tick_period - 1) begin
        bus.carrier_tick = 1'b1;
        tick_ctr = 0;
      end else begin
        bus.carrier_tick = 1'b0;
        tick_ctr++;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.burst_en) n_burst++;
    if (bus.cap_en) n_cap++;
    if (bus.done) n_done++;
    if (bus.burst_en && bus.cap_en) n_overlap++;
    if (bus.burst_en && bus.shift_bus != sb_prev) n_sbchg++;
    sb_prev = bus.shift_bus;
    if (prev_ch == 6'd0 && bus.tbl_addr[5:0] == 6'd1) step_log.push_back(int'(bus.tbl_addr[9:6]));
    prev_ch = bus.tbl_addr[5:0];
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_bank(input string name, input logic [SBW-1:0] got,
                            input logic [SBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bank({tag, "_shift"}, bus.shift_bus, '0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_addr"}, int'(bus.tbl_addr), 0);
    check({tag, "_step"}, int'(bus.step_idx), 0);
    check({tag, "_burst"}, int'(bus.burst_en), 0);
    check({tag, "_cap"}, int'(bus.cap_en), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic run_sweep(input int idx);
    vec_t  v;
    int    b0, c0, d0, o0, s0;
    bit    ok, poked;
    string p;
    v = vecs[idx];
    p = $sformatf("v%0d", idx);
    ok = 1'b0;
    poked = 1'b0;
    bus.num_steps  = 4'(v.ns);
    bus.burst_len  = 4'(v.bl);
    bus.listen_len = 16'(v.ll);
    bus.loop_en    = 1'b0;
    tick_period    = v.period;
    @(posedge clk);
    #1;
    b0 = n_burst; c0 = n_cap; d0 = n_done; o0 = n_overlap; s0 = n_sbchg;
    step_log.delete();
    pulse_start();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (v.poke && !poked && bus.cap_en) begin
        poked = 1'b1;
        pulse_start();
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check({p, "_done_seen"}, int'(ok), 1);
    check({p, "_burst_cycles"}, n_burst - b0, v.exp_burst);
    check({p, "_cap_cycles"}, n_cap - c0, v.exp_cap);
    check({p, "_done_count"}, n_done - d0, 1);
    check({p, "_overlap"}, n_overlap - o0, 0);
    check({p, "_shift_in_burst"}, n_sbchg - s0, 0);
    check({p, "_loads"}, step_log.size(), v.exp_steps);
    for (int i = 0; i < step_log.size(); i++) check({p, "_step_seq"}, step_log[i], i);
    check({p, "_final_step"}, int'(bus.step_idx), v.ns);
    check({p, "_busy_after"}, int'(bus.busy), 0);
    check_bank({p, "_shift_bus"}, bus.shift_bus, bank(v.ns));
  endtask

  initial begin
    int  d0;
    bit  ok;
    //         ns bl ll  per  poke  burst  cap  steps
    vecs[0] = '{0, 4, 8, 600, 1'b0, 2400, 4800, 1};
    vecs[1] = '{2, 2, 3,  20, 1'b0,  120,  180, 3};
    vecs[2] = '{0, 0, 0,  10, 1'b0,    0,    0, 1};
    vecs[3] = '{3, 0, 0,  10, 1'b0,    0,    0, 4};
    vecs[4] = '{1, 1, 0,  16, 1'b0,   32,    0, 2};
    vecs[5] = '{0, 0, 5,   8, 1'b0,    0,   40, 1};
    vecs[6] = '{1, 1, 4,  10, 1'b1,   20,   80, 2};
    vecs[7] = '{1, 1, 1,  10, 1'b0,   20,   20, 2};

    res_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.loop_en = 1'b0;
    bus.num_steps = 4'd0;
    bus.burst_len = 4'd0;
    bus.listen_len = 16'd0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    res_n = 1'b1;

    // start and abort together in IDLE: abort wins
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_busy_later", int'(bus.busy), 0);

    for (int i = 0; i < 7; i++) run_sweep(i);

    // looping sweep, aborted during the burst of the fourth step
    bus.num_steps = 4'd1;
    bus.burst_len = 4'd2;
    bus.listen_len = 16'd2;
    bus.loop_en = 1'b1;
    tick_period = 10;
    d0 = n_done;
    ok = 1'b0;
    step_log.delete();
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (step_log.size() >= 4 && bus.burst_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("loop_reached_step4_burst", int'(ok), 1);
    @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check("abort_burst_en", int'(bus.burst_en), 0);
    check("abort_cap_en", int'(bus.cap_en), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("loop_loads", step_log.size(), 4);
    for (int i = 0; i < step_log.size(); i++) check("loop_step_seq", step_log[i], i % 2);
    check_bank("abort_shift_kept", bus.shift_bus, bank(1));
    bus.loop_en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("loop_done_count", n_done - d0, 0);
    check("abort_stays_idle", int'(bus.busy), 0);

    // asynchronous reset in the middle of LOAD
    bus.num_steps = 4'd0;
    bus.burst_len = 4'd1;
    bus.listen_len = 16'd1;
    pulse_start();
    repeat (4) @(posedge clk);
    #3 res_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    res_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_release_idle", int'(bus.busy), 0);
    run_sweep(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
